// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage controller.
// Op encodings, FSM states and multiplier iteration count.
package ex_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_MUL  = 3'b011,
        OP_BEQ  = 3'b100,
        OP_JMP  = 3'b101,
        OP_PASS = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MUL_BUSY = 2'b01,
        ST_MUL_DONE = 2'b10
    } state_e;

    localparam int MUL_ITERS = 32;
    localparam int ITER_W    = $clog2(MUL_ITERS);

    // Ops whose result may be written to the register file.
    function automatic logic op_writes(op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_PASS};
    endfunction

endpackage

// File: rtl/ex_stage_ctl_if.sv
// RR/EX -> EX/WB bundle of the execute-stage controller.
// master = upstream/writeback side, slave = ex_stage_ctl.
interface ex_stage_ctl_if;

    logic        valid_in;
    logic [31:0] pc_in;
    logic [2:0]  instr_length_in;
    logic [6:0]  ctrl_in;
    logic [2:0]  dst_idx_in;
    logic [31:0] src1_in;
    logic [31:0] src2_in;
    logic        wb_stall;
    logic        stall_out;
    logic        flush_out;
    logic [31:0] redirect_pc;
    logic        res_valid;
    logic [31:0] res_data;
    logic [2:0]  res_dst;
    logic        res_we;

    modport master (
        output valid_in, pc_in, instr_length_in, ctrl_in,
        output dst_idx_in, src1_in, src2_in, wb_stall,
        input  stall_out, flush_out, redirect_pc,
        input  res_valid, res_data, res_dst, res_we
    );

    modport slave (
        input  valid_in, pc_in, instr_length_in, ctrl_in,
        input  dst_idx_in, src1_in, src2_in, wb_stall,
        output stall_out, flush_out, redirect_pc,
        output res_valid, res_data, res_dst, res_we
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Low 32 bits of unsigned a*b after MUL_ITERS cycles.
module ex_mul_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       acc_q;
    logic [31:0]       acc_d;
    logic [ITER_W-1:0] cnt_q;
    logic              busy_q;
    logic              last;

    assign last      = busy_q & (cnt_q == ITER_W'(MUL_ITERS - 1));
    assign done_o    = last;
    assign product_o = acc_q;

    // Add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q;
        if (b_q[0]) acc_d = acc_q + a_q;
    end

    // Load operands on start, then shift one bit per cycle until the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (last) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage_ctl.sv
// Execute-stage control: ALU, branch resolution, multiply sequencing.
// Define EX_FAST_MUL_EN for a single-cycle MUL instead of ex_mul_iter.
module ex_stage_ctl
    import ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_stage_ctl_if.slave bus
);

    op_e         op;
    logic        accept;
    logic        taken;
    logic [31:0] target;
    logic [31:0] alu_res;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_prod;
    logic        unused_ctrl;

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] redir_q, redir_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic [2:0]  res_dst_q, res_dst_d;
    logic        res_we_q, res_we_d;
    logic [2:0]  mul_dst_q, mul_dst_d;
    logic        mul_we_q, mul_we_d;

    assign op          = op_e'(bus.ctrl_in[2:0]);
    assign unused_ctrl = ^bus.ctrl_in[6:4];

    assign bus.stall_out   = (state_q != ST_IDLE) | bus.wb_stall;
    assign bus.flush_out   = flush_q;
    assign bus.redirect_pc = redir_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_dst     = res_dst_q;
    assign bus.res_we      = res_we_q;

    // Instructions arriving during the flush pulse are wrong-path.
    assign accept = bus.valid_in & ~bus.stall_out & ~bus.flush_out;

    assign taken  = ((op == OP_BEQ) & (bus.src1_in == bus.src2_in))
                  | (op == OP_JMP);
    assign target = (op == OP_JMP) ? bus.src2_in
                  : bus.pc_in + {29'b0, bus.instr_length_in} + bus.src2_in;

`ifdef EX_FAST_MUL_EN
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`else
    assign mul_start = accept & (op == OP_MUL);

    ex_mul_iter u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (bus.src1_in),
        .b_i       (bus.src2_in),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`endif

    // Single-cycle datapath result; branches and NOP produce zero.
    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = bus.src1_in + bus.src2_in;
            OP_SUB:  alu_res = bus.src1_in - bus.src2_in;
            OP_AND:  alu_res = bus.src1_in & bus.src2_in;
`ifdef EX_FAST_MUL_EN
            OP_MUL:  alu_res = bus.src1_in * bus.src2_in;
`else
            OP_MUL:  alu_res = '0;
`endif
            OP_PASS: alu_res = bus.src1_in;
            default: alu_res = '0;
        endcase
    end

    // Multiply sequencing: busy while iterating, done until writeback takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done) state_d = ST_MUL_DONE;
            ST_MUL_DONE: if (!bus.wb_stall) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next EX/WB result, flush pulse and redirect target.
    always_comb begin
        flush_d     = accept & taken;
        redir_d     = (accept & taken) ? target : redir_q;
        mul_dst_d   = mul_start ? bus.dst_idx_in : mul_dst_q;
        mul_we_d    = mul_start ? bus.ctrl_in[3] : mul_we_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_dst_d   = res_dst_q;
        res_we_d    = res_we_q;
        if (!bus.wb_stall) begin
            res_valid_d = 1'b0;
            if (state_q == ST_MUL_DONE) begin
                res_valid_d = 1'b1;
                res_data_d  = mul_prod;
                res_dst_d   = mul_dst_q;
                res_we_d    = mul_we_q;
            end else if (accept & ~mul_start) begin
                res_valid_d = 1'b1;
                res_data_d  = alu_res;
                res_dst_d   = bus.dst_idx_in;
                res_we_d    = bus.ctrl_in[3] & op_writes(op);
            end
        end
    end

    // Pipeline registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q     <= 1'b0;
            redir_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_dst_q   <= '0;
            res_we_q    <= 1'b0;
            mul_dst_q   <= '0;
            mul_we_q    <= 1'b0;
        end else begin
            flush_q     <= flush_d;
            redir_q     <= redir_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_dst_q   <= res_dst_d;
            res_we_q    <= res_we_d;
            mul_dst_q   <= mul_dst_d;
            mul_we_q    <= mul_we_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_ctl.sv
// Self-checking bench for ex_stage_ctl: directed cases plus a
// randomized stream checked against a transaction-level model.
module tb_ex_stage_ctl;
    import ex_pkg::*;

`ifdef EX_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ex_stage_ctl_if bus ();

    ex_stage_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic we,
                         input logic [2:0] dst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc,
                         input logic [2:0] len);
        logic [2:0] rsv;
        rsv = 3'($urandom_range(0, 7));
        bus.valid_in        = v;
        bus.ctrl_in         = {rsv, we, op};
        bus.dst_idx_in      = dst;
        bus.src1_in         = a;
        bus.src2_in         = b;
        bus.pc_in           = pc;
        bus.instr_length_in = len;
    endtask

    task automatic drive_idle;
        drive(1'b0, OP_NOP, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    endtask

    function automatic logic [31:0] ref_result(logic [2:0] op, logic [31:0] a,
                                               logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a * b;
            3'b110:  return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset;
        bus.wb_stall = 1'b0;
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.stall_out !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.stall_out); else n_pass++;
        n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL rst_flush got %b want 0", bus.flush_out); else n_pass++;
        n_checks++; if (bus.redirect_pc !== 32'd0) $display("FAIL rst_redir got %h want 0", bus.redirect_pc); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.res_valid); else n_pass++;
        n_checks++; if (bus.res_data !== 32'd0) $display("FAIL rst_data got %h want 0", bus.res_data); else n_pass++;
        n_checks++; if (bus.res_dst !== 3'd0) $display("FAIL rst_dst got %0d want 0", bus.res_dst); else n_pass++;
        n_checks++; if (bus.res_we !== 1'b0) $display("FAIL rst_we got %b want 0", bus.res_we); else n_pass++;
        // reset beats an accepted jump in the same cycle
        drive(1'b1, OP_JMP, 1'b1, 3'd3, 32'd0, 32'h1234, 32'd0, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        #1;
        n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL rstprio_flush got %b want 0", bus.flush_out); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL rstprio_valid got %b want 0", bus.res_valid); else n_pass++;
        n_checks++; if (bus.redirect_pc !== 32'd0) $display("FAIL rstprio_redir got %h want 0", bus.redirect_pc); else n_pass++;
    endtask

    task automatic test_alu;
        logic [2:0]  ops [5] = '{OP_ADD, OP_SUB, OP_AND, OP_PASS, OP_NOP};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_FF00, 32'hCAFE_BABE, 32'd9};
        logic [31:0] bs  [5] = '{32'd1, 32'd7, 32'h0FF0_F0F0, 32'd3, 32'd9};
        logic [31:0] exp [5] = '{32'd0, 32'hFFFF_FFFE, 32'h00F0_F000, 32'hCAFE_BABE, 32'd0};
        logic [2:0]  dsts[5] = '{3'd5, 3'd1, 3'd7, 3'd2, 3'd4};
        logic        wes [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        xwe [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], wes[i], dsts[i], as[i], bs[i], 32'h40, 3'd4);
            tick();
            n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL alu%0d_valid got %b want 1", i, bus.res_valid); else n_pass++;
            n_checks++; if (bus.res_dst !== dsts[i]) $display("FAIL alu%0d_dst got %0d want %0d", i, bus.res_dst, dsts[i]); else n_pass++;
            n_checks++; if (bus.res_we !== xwe[i]) $display("FAIL alu%0d_we got %b want %b", i, bus.res_we, xwe[i]); else n_pass++;
            if (i < 4) begin
                n_checks++; if (bus.res_data !== exp[i]) $display("FAIL alu%0d_data got %h want %h", i, bus.res_data, exp[i]); else n_pass++;
            end
            n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL alu%0d_flush got %b want 0", i, bus.flush_out); else n_pass++;
        end
        drive_idle();
        tick();
        n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL alu_bubble got %b want 0", bus.res_valid); else n_pass++;
    endtask

    task automatic test_branch;
        drive(1'b1, OP_BEQ, 1'b1, 3'd3, 32'd7, 32'd7, 32'h100, 3'd2);
        tick();
        drive(1'b1, OP_ADD, 1'b1, 3'd6, 32'd1, 32'd1, 32'd0, 3'd0);
        #1;
        n_checks++; if (bus.flush_out !== 1'b1) $display("FAIL beq_flush got %b want 1", bus.flush_out); else n_pass++;
        n_checks++; if (bus.redirect_pc !== 32'h109) $display("FAIL beq_target got %h want 109", bus.redirect_pc); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL beq_valid got %b want 1", bus.res_valid); else n_pass++;
        n_checks++; if (bus.res_we !== 1'b0) $display("FAIL beq_we got %b want 0", bus.res_we); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL beq_pulse got %b want 0", bus.flush_out); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL wrongpath_valid got %b want 0", bus.res_valid); else n_pass++;
        drive(1'b1, OP_BEQ, 1'b1, 3'd2, 32'd1, 32'd2, 32'h200, 3'd4);
        tick();
        drive(1'b1, OP_JMP, 1'b1, 3'd1, 32'd0, 32'hDEAD_0000, 32'h300, 3'd1);
        #1;
        n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL bnt_flush got %b want 0", bus.flush_out); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL bnt_valid got %b want 1", bus.res_valid); else n_pass++;
        n_checks++; if (bus.res_we !== 1'b0) $display("FAIL bnt_we got %b want 0", bus.res_we); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus.flush_out !== 1'b1) $display("FAIL jmp_flush got %b want 1", bus.flush_out); else n_pass++;
        n_checks++; if (bus.redirect_pc !== 32'hDEAD_0000) $display("FAIL jmp_target got %h want dead0000", bus.redirect_pc); else n_pass++;
        n_checks++; if (bus.res_we !== 1'b0) $display("FAIL jmp_we got %b want 0", bus.res_we); else n_pass++;
        tick();
        n_checks++; if (bus.flush_out !== 1'b0) $display("FAIL jmp_pulse got %b want 0", bus.flush_out); else n_pass++;
    endtask

    task automatic test_mul;
        logic [31:0] as  [2] = '{32'h0001_0000, 32'd3};
        logic [31:0] bs  [2] = '{32'h0001_0000, 32'd5};
        logic [31:0] exp [2] = '{32'h0000_0000, 32'd15};
        int cnt;
        int early;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, OP_MUL, 1'b1, 3'(2 + i), as[i], bs[i], 32'd0, 3'd0);
            #1;
            n_checks++; if (bus.stall_out !== 1'b0) $display("FAIL mul%0d_pre_stall got %b want 0", i, bus.stall_out); else n_pass++;
            tick();
            drive_idle();
            cnt = 0;
            early = 0;
            while (bus.stall_out === 1'b1 && cnt < 100) begin
                if (bus.res_valid !== 1'b0) early++;
                tick();
                cnt++;
            end
            n_checks++; if (cnt !== MUL_LAT) $display("FAIL mul%0d_stall_cycles got %0d want %0d", i, cnt, MUL_LAT); else n_pass++;
            n_checks++; if (early !== 0) $display("FAIL mul%0d_early got %0d want 0", i, early); else n_pass++;
            n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL mul%0d_valid got %b want 1", i, bus.res_valid); else n_pass++;
            n_checks++; if (bus.res_data !== exp[i]) $display("FAIL mul%0d_data got %h want %h", i, bus.res_data, exp[i]); else n_pass++;
            n_checks++; if (bus.res_dst !== 3'(2 + i)) $display("FAIL mul%0d_dst got %0d want %0d", i, bus.res_dst, 2 + i); else n_pass++;
            n_checks++; if (bus.res_we !== 1'b1) $display("FAIL mul%0d_we got %b want 1", i, bus.res_we); else n_pass++;
        end
        tick();
    endtask

    task automatic test_wb_stall;
        drive(1'b1, OP_ADD, 1'b1, 3'd1, 32'd2, 32'd3, 32'd0, 3'd0);
        tick();
        drive(1'b1, OP_ADD, 1'b1, 3'd4, 32'd10, 32'd20, 32'd0, 3'd0);
        bus.wb_stall = 1'b1;
        #1;
        n_checks++; if (bus.stall_out !== 1'b1) $display("FAIL wbs_stall got %b want 1", bus.stall_out); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL wbs%0d_valid got %b want 1", i, bus.res_valid); else n_pass++;
            n_checks++; if (bus.res_data !== 32'd5) $display("FAIL wbs%0d_data got %h want 5", i, bus.res_data); else n_pass++;
            n_checks++; if (bus.res_dst !== 3'd1) $display("FAIL wbs%0d_dst got %0d want 1", i, bus.res_dst); else n_pass++;
        end
        bus.wb_stall = 1'b0;
        #1;
        n_checks++; if (bus.stall_out !== 1'b0) $display("FAIL wbs_release got %b want 0", bus.stall_out); else n_pass++;
        tick();
        drive_idle();
        n_checks++; if (bus.res_data !== 32'd30) $display("FAIL wbs_next_data got %h want 1e", bus.res_data); else n_pass++;
        n_checks++; if (bus.res_dst !== 3'd4) $display("FAIL wbs_next_dst got %0d want 4", bus.res_dst); else n_pass++;
        tick();
    endtask

    task automatic test_rst_mid_mul;
        int bad;
        drive(1'b1, OP_MUL, 1'b1, 3'd3, 32'd3, 32'd5, 32'd0, 3'd0);
        tick();
        drive_idle();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.stall_out !== 1'b0) $display("FAIL rstmul_stall got %b want 0", bus.stall_out); else n_pass++;
        n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL rstmul_valid got %b want 0", bus.res_valid); else n_pass++;
        bad = 0;
        repeat (40) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.stall_out !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL rstmul_late got %0d want 0", bad); else n_pass++;
    endtask

    task automatic test_random;
        int          left;
        logic [31:0] prod, redir, rdata, a, b, pc;
        logic [2:0]  mdst, rdst, op, dst, len;
        logic        mwe, rwe, rv, flush, rdchk, v, we, wb;
        logic        exp_stall, acc, taken, nflush, alu_op;
        rst = 1'b1;
        drive_idle();
        bus.wb_stall = 1'b0;
        tick();
        rst = 1'b0;
        left = 0; prod = 0; redir = 0; rdata = 0; mdst = 0; rdst = 0;
        mwe = 0; rwe = 0; rv = 0; flush = 0; rdchk = 0;
        for (int c = 0; c < 500; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            op  = 3'($urandom_range(0, 7));
            if (op == OP_MUL && $urandom_range(0, 3) != 0) op = OP_ADD;
            we  = 1'($urandom_range(0, 1));
            dst = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? a : $urandom;
            pc  = $urandom;
            len = 3'($urandom_range(0, 7));
            wb  = ($urandom_range(0, 4) == 0);
            drive(v, op, we, dst, a, b, pc, len);
            bus.wb_stall = wb;
            #1;
            exp_stall = (left > 0) || wb;
            n_checks++; if (bus.stall_out !== exp_stall) $display("FAIL rnd%0d_stall got %b want %b", c, bus.stall_out, exp_stall); else n_pass++;
            n_checks++; if (bus.flush_out !== flush) $display("FAIL rnd%0d_flush got %b want %b", c, bus.flush_out, flush); else n_pass++;
            if (flush) begin
                n_checks++; if (bus.redirect_pc !== redir) $display("FAIL rnd%0d_redir got %h want %h", c, bus.redirect_pc, redir); else n_pass++;
            end
            acc    = v && !exp_stall && !flush;
            taken  = (op == OP_BEQ && a == b) || op == OP_JMP;
            nflush = acc && taken;
            if (nflush) redir = (op == OP_JMP) ? b : pc + 32'(len) + b;
            alu_op = op inside {OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_PASS};
            if (!wb) begin
                if (left == 1) begin
                    rv = 1; rdata = prod; rdst = mdst; rwe = mwe; rdchk = 1; left = 0;
                end else if (acc && !(op == OP_MUL && MUL_LAT > 0)) begin
                    rv = 1; rdata = ref_result(op, a, b); rdst = dst;
                    rwe = we && alu_op; rdchk = alu_op;
                end else begin
                    rv = 0;
                end
            end
            if (left > 1) left--;
            if (acc && op == OP_MUL && MUL_LAT > 0) begin
                left = MUL_LAT; prod = a * b; mdst = dst; mwe = we;
            end
            flush = nflush;
            tick();
            n_checks++; if (bus.res_valid !== rv) $display("FAIL rnd%0d_valid got %b want %b", c, bus.res_valid, rv); else n_pass++;
            if (rv) begin
                n_checks++; if (bus.res_dst !== rdst) $display("FAIL rnd%0d_dst got %0d want %0d", c, bus.res_dst, rdst); else n_pass++;
                n_checks++; if (bus.res_we !== rwe) $display("FAIL rnd%0d_we got %b want %b", c, bus.res_we, rwe); else n_pass++;
                if (rdchk) begin
                    n_checks++; if (bus.res_data !== rdata) $display("FAIL rnd%0d_data got %h want %h", c, bus.res_data, rdata); else n_pass++;
                end
            end
        end
        drive_idle();
        bus.wb_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.wb_stall = 1'b0;
        drive_idle();
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_wb_stall();
        test_rst_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
